// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU operation codes, FSM state codes and datapath mux select codes.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU operation map. funct_valid flags the supported set;
// unsupported functs fall back to ADD so the ALU select is never undefined.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_valid
);

   // funct lookup
   always_comb begin
      alu_control = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_XOR:  alu_control = ALU_XOR;
         FN_SLT:  alu_control = ALU_SLT;
         FN_SLL:  alu_control = ALU_SLL;
         FN_SRL:  alu_control = ALU_SRL;
         default: funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  FETCH    | read instruction at PC, load IR, PC += 4 (waits on memory)
//  DECODE   | classify opcode, precompute branch target into ALUOut
//  MEMADR   | base + offset for lw/sw
//  MEMRD    | data read at ALUOut (waits on memory)
//  MEMWB    | write loaded data to rt
//  MEMWR    | data write at ALUOut (waits on memory)
//  EXECUTE  | R-type ALU operation
//  ALUWB    | write ALU result to rd
//  BRANCH   | compare A/B, load PC from ALUOut on taken
//  ADDIEX   | A + SignImm
//  ADDIWB   | write addi result to rt
//  JUMP     | load PC with jump target
//
// Branch flavour and lw/sw direction are captured in DECODE so later
// states never look at opcode again.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit HAS_BNE       = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUControl,
   output logic       illegal_instr,
   output logic [3:0] state
);

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       is_sw_q;
   logic       is_bne_q;
   logic       ready;
   logic [2:0] funct_alu;
   logic       funct_valid;

   logic       pcen_raw;
   logic       irwrite_raw;
   logic       memwrite_raw;
   logic       regwrite_raw;
   logic       illegal_raw;

   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   mips_alu_decoder u_alu_decoder (
      .funct       (funct),
      .alu_control (funct_alu),
      .funct_valid (funct_valid)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // instruction flavour captured while IR is known stable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_sw_q  <= 1'b0;
         is_bne_q <= 1'b0;
      end else if (state_q == S_DECODE) begin
         is_sw_q  <= (opcode == OP_SW);
         is_bne_q <= (opcode == OP_BNE);
      end
   end

   // next-state logic and illegal detection
   always_comb begin
      state_d     = state_q;
      illegal_raw = 1'b0;
      case (state_q)
         S_FETCH:   if (ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_valid) begin
                     state_d = S_EXECUTE;
                  end else begin
                     state_d     = S_FETCH;
                     illegal_raw = 1'b1;
                  end
               end
               OP_BEQ:  state_d = S_BRANCH;
               OP_BNE: begin
                  if (HAS_BNE) begin
                     state_d = S_BRANCH;
                  end else begin
                     state_d     = S_FETCH;
                     illegal_raw = 1'b1;
                  end
               end
               OP_ADDI: state_d = S_ADDIEX;
               OP_J:    state_d = S_JUMP;
               default: begin
                  state_d     = S_FETCH;
                  illegal_raw = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (ready) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // per-state datapath controls
   always_comb begin
      pcen_raw     = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      IorD         = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = SRCB_REG;
      PCSrc        = PCSRC_ALU;
      ALUControl   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcB     = SRCB_FOUR;
            irwrite_raw = ready;
            pcen_raw    = ready;
         end
         S_DECODE:  ALUSrcB = SRCB_IMM_SH2;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD:   IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg     = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_MEMWR: begin
            IorD         = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA    = 1'b1;
            ALUControl = funct_alu;
         end
         S_ALUWB: begin
            RegDst       = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = PCSRC_ALUOUT;
            pcen_raw   = is_bne_q ? ~Zero : Zero;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDIWB:  regwrite_raw = 1'b1;
         S_JUMP: begin
            PCSrc    = PCSRC_JUMP;
            pcen_raw = 1'b1;
         end
         default: ;
      endcase
   end

   // strobes are killed combinationally so nothing leaks while reset is low
   assign PCEn          = pcen_raw     & reset_n;
   assign IRWrite       = irwrite_raw  & reset_n;
   assign MemWrite      = memwrite_raw & reset_n;
   assign RegWrite      = regwrite_raw & reset_n;
   assign illegal_instr = illegal_raw  & reset_n;
   assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. The reference is a per-instruction list of
// expected phases built from the instruction's semantics; phases that touch
// memory hold while mem_ready is low.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic       illegal_instr;
   logic [3:0] state;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .Zero(Zero),
      .mem_ready(mem_ready), .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
      .illegal_instr(illegal_instr), .state(state)
   );

   always #5 clk = ~clk;

   // pcen_kind: 0 never, 1 follows mem_ready, 2 Zero, 3 ~Zero, 4 always
   typedef struct {
      int       st;
      bit       iord, srca, regdst, memtoreg, regwrite, memwrite, irw_rdy, illegal, waits;
      bit [1:0] srcb, pcsrc;
      bit [2:0] aluc;
      int       pcen_kind;
   } phase_t;

   phase_t exp_q[$];
   int     tests = 0;
   int     fails = 0;

   function automatic phase_t ph(input int st);
      phase_t p;
      p = '{default: 0};
      p.st   = st;
      p.aluc = 3'b010;
      return p;
   endfunction

   function automatic bit [3:0] r_type_op(input logic [5:0] f);
      // {legal, alu code}
      case (f)
         6'b100000: return 4'b1_010;
         6'b100010: return 4'b1_110;
         6'b100100: return 4'b1_000;
         6'b100101: return 4'b1_001;
         6'b100110: return 4'b1_011;
         6'b101010: return 4'b1_111;
         6'b000000: return 4'b1_100;
         6'b000010: return 4'b1_101;
         default:   return 4'b0_010;
      endcase
   endfunction

   task automatic build(input logic [5:0] op, input logic [5:0] fn);
      phase_t   p;
      bit [3:0] r;
      bit       legal;
      r = r_type_op(fn);
      p = ph(0); p.srcb = 2'b01; p.irw_rdy = 1; p.pcen_kind = 1; p.waits = 1;
      exp_q.push_back(p);
      legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
              (op == 6'b000101) || (op == 6'b001000) || (op == 6'b000010) ||
              (op == 6'b000000 && r[3]);
      p = ph(1); p.srcb = 2'b11; p.illegal = !legal;
      exp_q.push_back(p);
      if (!legal) return;
      case (op)
         6'b100011, 6'b101011: begin
            p = ph(2); p.srca = 1; p.srcb = 2'b10; exp_q.push_back(p);
            if (op == 6'b100011) begin
               p = ph(3); p.iord = 1; p.waits = 1; exp_q.push_back(p);
               p = ph(4); p.memtoreg = 1; p.regwrite = 1; exp_q.push_back(p);
            end else begin
               p = ph(5); p.iord = 1; p.memwrite = 1; p.waits = 1; exp_q.push_back(p);
            end
         end
         6'b000000: begin
            p = ph(6); p.srca = 1; p.aluc = r[2:0]; exp_q.push_back(p);
            p = ph(7); p.regdst = 1; p.regwrite = 1; exp_q.push_back(p);
         end
         6'b000100, 6'b000101: begin
            p = ph(8); p.srca = 1; p.aluc = 3'b110; p.pcsrc = 2'b01;
            p.pcen_kind = (op == 6'b000100) ? 2 : 3;
            exp_q.push_back(p);
         end
         6'b001000: begin
            p = ph(9); p.srca = 1; p.srcb = 2'b10; exp_q.push_back(p);
            p = ph(10); p.regwrite = 1; exp_q.push_back(p);
         end
         default: begin
            p = ph(11); p.pcsrc = 2'b10; p.pcen_kind = 4; exp_q.push_back(p);
         end
      endcase
   endtask

   // per-cycle comparison of every output against the head phase
   phase_t      cp;
   logic        pcen_e;
   logic [19:0] exp_v, act_v;
   always @(negedge clk) begin
      if (reset_n && exp_q.size() > 0) begin
         cp = exp_q[0];
         case (cp.pcen_kind)
            1:       pcen_e = mem_ready;
            2:       pcen_e = Zero;
            3:       pcen_e = !Zero;
            4:       pcen_e = 1'b1;
            default: pcen_e = 1'b0;
         endcase
         exp_v = {4'(cp.st), pcen_e, cp.iord, cp.memwrite, cp.irw_rdy & mem_ready, cp.regdst,
                  cp.memtoreg, cp.regwrite, cp.srca, cp.srcb, cp.pcsrc, cp.aluc, cp.illegal};
         act_v = {state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal_instr};
         tests++;
         if (act_v !== exp_v) begin
            fails++;
            $display("FAIL cycle_check t=%0t phase=%0d actual=%b required=%b", $time, cp.st, act_v, exp_v);
         end
         if (!cp.waits || mem_ready) void'(exp_q.pop_front());
      end
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // inputs for one cycle; called just after a rising edge
   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input bit rnd,
                        input bit zval, inout int low);
      int head;
      head = exp_q[0].st;
      if (rnd) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         Zero      = 1'($urandom_range(0, 1));
      end else begin
         Zero      = zval;
         mem_ready = 1'b1;
         if (head == 5 && low > 0) begin
            mem_ready = 1'b0;
            low--;
         end
      end
      if (head == 1 || head == 6) begin
         opcode = op;
         funct  = fn;
      end else begin
         opcode = 6'($urandom);
         funct  = 6'($urandom);
      end
   endtask

   // runs one instruction from FETCH back to FETCH; entered just after a rising edge
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit rnd,
                            input bit zval, input int low_memwr, output int cycles,
                            output int memwr_cycles, output int exec_alu,
                            output int ill, output int br_pcen);
      int low;
      low = low_memwr;
      cycles = 0; memwr_cycles = 0; exec_alu = -1; ill = 0; br_pcen = -1;
      build(op, fn);
      while (1) begin
         drive(op, fn, rnd, zval, low);
         @(negedge clk); #1;
         cycles++;
         if (state == 4'd5 && MemWrite) memwr_cycles++;
         if (state == 4'd6) exec_alu = int'(ALUControl);
         if (state == 4'd8) br_pcen = int'(PCEn);
         if (illegal_instr) ill++;
         @(posedge clk); #1;
         if (exp_q.size() == 0) break;
         if (cycles > 60) begin
            tests++; fails++;
            $display("FAIL timeout op=%b actual=%0d cycles required=done", op, cycles);
            exp_q.delete();
            break;
         end
      end
   endtask

   // pulls reset while the instruction sits in the target phase
   task automatic reset_in(input logic [5:0] op, input logic [5:0] fn, input int target,
                           input string name);
      int low;
      int n;
      low = 5;
      n = 0;
      build(op, fn);
      while (exp_q.size() > 0 && exp_q[0].st != target && n < 20) begin
         drive(op, fn, 1'b0, 1'b0, low);
         @(negedge clk); #1;
         @(posedge clk); #1;
         n++;
      end
      drive(op, fn, 1'b0, 1'b0, low);
      #1;
      check({name, "_strobe_before"}, int'(target == 5 ? MemWrite : RegWrite), 1);
      reset_n = 1'b0;
      #1;
      check({name, "_strobe_after"}, int'(MemWrite | RegWrite), 0);
      check({name, "_state_after"}, int'(state), 0);
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      reset_n = 1'b1;
   endtask

   int c, mw, ea, il, bp;
   logic [5:0] ops [7];
   logic [5:0] fns [8];

   initial begin
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010, 6'b000000, 6'b000010};

      reset_n = 1'b0;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", int'(state), 0);
      check("reset_strobes", int'({PCEn, IRWrite, MemWrite, RegWrite, illegal_instr}), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      check("first_fetch_strobes", int'({IRWrite, PCEn}), 3);

      run_instr(6'b100011, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("lw_latency", c, 5);
      run_instr(6'b101011, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("sw_latency", c, 4);
      run_instr(6'b000000, 6'b100010, 0, 0, 0, c, mw, ea, il, bp);
      check("sub_latency", c, 4);
      check("sub_alucontrol", ea, 6);
      run_instr(6'b000000, 6'b000010, 0, 0, 0, c, mw, ea, il, bp);
      check("srl_alucontrol", ea, 5);
      run_instr(6'b000000, 6'b111111, 0, 0, 0, c, mw, ea, il, bp);
      check("bad_funct_illegal", il, 1);
      check("bad_funct_latency", c, 2);
      run_instr(6'b111111, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("bad_opcode_illegal", il, 1);
      run_instr(6'b001000, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("addi_latency", c, 4);
      run_instr(6'b000010, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("j_latency", c, 3);
      run_instr(6'b000100, 6'd0, 0, 1, 0, c, mw, ea, il, bp);
      check("beq_taken_pcen", bp, 1);
      check("beq_latency", c, 3);
      run_instr(6'b000100, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("beq_not_taken_pcen", bp, 0);
      run_instr(6'b000101, 6'd0, 0, 1, 0, c, mw, ea, il, bp);
      check("bne_zero_pcen", bp, 0);
      run_instr(6'b000101, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("bne_nonzero_pcen", bp, 1);
      run_instr(6'b101011, 6'd0, 0, 0, 3, c, mw, ea, il, bp);
      check("sw_wait_memwrite_cycles", mw, 4);
      check("sw_wait_latency", c, 7);

      reset_in(6'b101011, 6'd0, 5, "reset_in_memwr");
      run_instr(6'b000000, 6'b100000, 0, 0, 0, c, mw, ea, il, bp);
      check("after_reset_add_latency", c, 4);
      reset_in(6'b000000, 6'b100101, 7, "reset_in_aluwb");
      run_instr(6'b100011, 6'd0, 0, 0, 0, c, mw, ea, il, bp);
      check("after_reset_lw_latency", c, 5);

      for (int i = 0; i < 200; i++) begin
         logic [5:0] op, fn;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
         run_instr(op, fn, 1, 0, 0, c, mw, ea, il, bp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
